// File: rtl/rx_frame_checker.sv
// Receive-side frame checker: captures frames, flags parity/framing errors,
// queues results in a small FIFO and keeps saturating error counters.
module rx_frame_checker #(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_valid,
  input  logic [DATA_W-1:0]    frame_data,
  input  logic                 frame_parity,
  input  logic [STOP_BITS-1:0] frame_stop,
  input  logic                 par_en,
  input  logic                 p_type,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_par_err,
  output logic                 out_frm_err,
  output logic                 overrun,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     par_err_cnt,
  output logic [CNT_W-1:0]     frm_err_cnt,
  output logic [CNT_W-1:0]     ovr_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              par_err;
    logic              frm_err;
  } entry_t;

  // Stage 1: capture the frame together with the parity settings in force
  logic                 s1_valid;
  logic [DATA_W-1:0]    s1_data;
  logic                 s1_parity;
  logic [STOP_BITS-1:0] s1_stop;
  logic                 s1_par_en;
  logic                 s1_p_type;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_parity <= 1'b0;
      s1_stop   <= '0;
      s1_par_en <= 1'b0;
      s1_p_type <= 1'b0;
    end else begin
      s1_valid <= frame_valid;
      if (frame_valid) begin
        s1_data   <= frame_data;
        s1_parity <= frame_parity;
        s1_stop   <= frame_stop;
        s1_par_en <= par_en;
        s1_p_type <= p_type;
      end
    end
  end

  logic s1_par_err;
  logic s1_frm_err;

  assign s1_par_err = s1_par_en & (s1_p_type ? (^{s1_data, s1_parity})
                                             : (~^{s1_data, s1_parity}));
  assign s1_frm_err = ~&s1_stop;

  // FIFO control
  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           push;
  logic           pop;

  assign full      = (count == DEPTH_C);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = s1_valid & (~full | pop);
  assign overrun   = s1_valid & full & ~pop;

  // NOTE: the storage array has no reset; stale entries are unreachable because out_valid gates the head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: s1_data, par_err: s1_par_err, frm_err: s1_frm_err};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  entry_t head;

  assign head        = mem[rd_ptr];
  assign out_data    = out_valid ? head.data    : '0;
  assign out_par_err = out_valid ? head.par_err : 1'b0;
  assign out_frm_err = out_valid ? head.frm_err : 1'b0;

  // Error counters count every checked frame, including ones that get dropped
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      par_err_cnt <= '0;
      frm_err_cnt <= '0;
      ovr_cnt     <= '0;
    end else begin
      par_err_cnt <= sat_inc(par_err_cnt, s1_valid & s1_par_err);
      frm_err_cnt <= sat_inc(frm_err_cnt, s1_valid & s1_frm_err);
      ovr_cnt     <= sat_inc(ovr_cnt, overrun);
    end
  end

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker: a default-config instance with a
// scoreboard on its output FIFO, plus a STOP_BITS=2 / CNT_W=2 instance.
module tb_rx_frame_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       fv, fv2;
  logic [7:0] fdata;
  logic       fpar;
  logic       fstop;
  logic [1:0] fstop2;
  logic       par_en, p_type;
  logic       out_ready;
  logic       out_ready2;
  logic       clr_cnt;

  logic       out_valid, out_par_err, out_frm_err, overrun;
  logic [7:0] out_data, par_err_cnt, frm_err_cnt, ovr_cnt;

  logic       out_valid2, out_par_err2, out_frm_err2, overrun2;
  logic [7:0] out_data2;
  logic [1:0] par_err_cnt2, frm_err_cnt2, ovr_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  rx_frame_checker dut (
    .clk(clk), .rst(rst), .frame_valid(fv), .frame_data(fdata),
    .frame_parity(fpar), .frame_stop(fstop), .par_en(par_en), .p_type(p_type),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_par_err(out_par_err), .out_frm_err(out_frm_err), .overrun(overrun),
    .clr_cnt(clr_cnt), .par_err_cnt(par_err_cnt), .frm_err_cnt(frm_err_cnt),
    .ovr_cnt(ovr_cnt)
  );

  rx_frame_checker #(.DATA_W(8), .STOP_BITS(2), .DEPTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .frame_valid(fv2), .frame_data(fdata),
    .frame_parity(fpar), .frame_stop(fstop2), .par_en(par_en), .p_type(p_type),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_par_err(out_par_err2), .out_frm_err(out_frm_err2), .overrun(overrun2),
    .clr_cnt(clr_cnt), .par_err_cnt(par_err_cnt2), .frm_err_cnt(frm_err_cnt2),
    .ovr_cnt(ovr_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Independent parity model: count ones, odd parity wants an odd total
  function automatic logic exp_par_err(input logic [7:0] d, input logic p);
    int ones;
    ones = $countones({d, p});
    if (!par_en) return 1'b0;
    return p_type ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  // Drive one frame for a cycle; queue its expected result if the FIFO should take it
  task automatic send(input logic [7:0] d, input logic p, input logic s, input bit accept);
    exp_t x;
    fdata = d;
    fpar  = p;
    fstop = s;
    fv    = 1'b1;
    if (accept) begin
      x.d  = d;
      x.pe = exp_par_err(d, p);
      x.fe = ~s;
      q.push_back(x);
    end
    step;
    fv = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic p, input logic [1:0] s);
    fdata  = d;
    fpar   = p;
    fstop2 = s;
    fv2    = 1'b1;
    step;
    fv2 = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (20) begin
      if (q.size() != 0 || out_valid !== 1'b0) step;
    end
    check(tag, (q.size() == 0 && out_valid === 1'b0), 1);
  endtask

  // Output monitor: every accepted head is compared against the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out", out_data, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        check("sb_data", out_data, e.d);
        check("sb_par_err", out_par_err, e.pe);
        check("sb_frm_err", out_frm_err, e.fe);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fv = 1'b0; fv2 = 1'b0; fdata = '0; fpar = 1'b0;
    fstop = 1'b1; fstop2 = 2'b11; par_en = 1'b0; p_type = 1'b0;
    out_ready = 1'b0; out_ready2 = 1'b1; clr_cnt = 1'b0;
    step;
    step;
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_out_data", out_data, 0);
    check("rst_cnts", {par_err_cnt, frm_err_cnt, ovr_cnt}, 0);
    rst = 1'b0;
    step;

    // Good even-parity frame, two-cycle latency, head held while not ready
    par_en = 1'b1; p_type = 1'b1;
    send(8'h5A, 1'b0, 1'b1, 1);
    check("lat_n1_valid", out_valid, 0);
    step;
    check("lat_n2_valid", out_valid, 1);
    check("lat_n2_data", out_data, 8'h5A);
    check("lat_n2_errs", {out_par_err, out_frm_err}, 0);
    step;
    check("hold_data", out_data, 8'h5A);
    out_ready = 1'b1;
    drain("drain_first");

    // Odd parity mismatch, then the same frame with parity disabled
    p_type = 1'b0;
    send(8'h5A, 1'b0, 1'b1, 1);
    step;
    check("par_err_cnt_1", par_err_cnt, 1);
    par_en = 1'b0;
    send(8'h5A, 1'b0, 1'b1, 1);
    step;
    check("par_err_cnt_hold", par_err_cnt, 1);

    // Missing stop bit
    send(8'h00, 1'b0, 1'b0, 1);
    step;
    check("frm_err_cnt_1", frm_err_cnt, 1);
    drain("drain_errs");

    // Fill a stalled FIFO with five back-to-back frames; the fifth is dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 1'b0, 1'b1, i <= 4);
      check($sformatf("overrun_f%0d", i), overrun, (i == 5));
    end
    check("full_hold_data", out_data, 8'h01);
    step;
    check("overrun_pulse_end", overrun, 0);
    check("ovr_cnt_1", ovr_cnt, 1);

    // Full FIFO with a simultaneous pop and push: no drop
    send(8'h06, 1'b0, 1'b1, 1);
    out_ready = 1'b1;
    #1;
    check("push_pop_full_overrun", overrun, 0);
    step;
    out_ready = 1'b0;
    check("ovr_cnt_after_pp", ovr_cnt, 1);

    // Still full: another frame is dropped
    send(8'h07, 1'b0, 1'b1, 0);
    check("overrun_f7", overrun, 1);
    step;
    check("ovr_cnt_2", ovr_cnt, 2);
    out_ready = 1'b1;
    drain("drain_full");

    clr_cnt = 1'b1;
    step;
    clr_cnt = 1'b0;
    check("clr_cnts", {par_err_cnt, frm_err_cnt, ovr_cnt}, 0);

    // Two stop bits, only the first one valid
    par_en = 1'b1; p_type = 1'b1;
    send2(8'h0F, 1'b0, 2'b10);
    step;
    check("sb2_valid", out_valid2, 1);
    check("sb2_data", out_data2, 8'h0F);
    check("sb2_frm_err", out_frm_err2, 1);
    check("sb2_par_err", out_par_err2, 0);
    check("sb2_frm_cnt", frm_err_cnt2, 1);

    // Two-bit counter saturates after five parity errors
    for (int i = 0; i < 5; i++) send2(8'h01, 1'b0, 2'b11);
    step;
    check("sat_par_cnt", par_err_cnt2, 3);
    send2(8'h01, 1'b0, 2'b11);
    clr_cnt = 1'b1;
    step;
    clr_cnt = 1'b0;
    check("clr_prio_par", par_err_cnt2, 0);
    check("clr_prio_frm", frm_err_cnt2, 0);

    // Reset with two frames queued and a frame arriving in the same cycle
    out_ready = 1'b0;
    par_en = 1'b1; p_type = 1'b0;
    send(8'h11, 1'b0, 1'b1, 1);
    send(8'h22, 1'b0, 1'b1, 1);
    step;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_par_cnt", par_err_cnt, 2);
    rst = 1'b1;
    fv = 1'b1; fdata = 8'h77; fpar = 1'b0; fstop = 1'b0;
    step;
    fv = 1'b0;
    rst = 1'b0;
    q.delete();
    check("rst2_out_valid", out_valid, 0);
    check("rst2_overrun", overrun, 0);
    check("rst2_out_data", {out_data, out_par_err, out_frm_err}, 0);
    check("rst2_cnts", {par_err_cnt, frm_err_cnt, ovr_cnt}, 0);
    out_ready = 1'b1;
    repeat (6) step;
    check("no_stale_valid", out_valid, 0);
    check("no_stale_cnts", {par_err_cnt, frm_err_cnt}, 0);
    par_en = 1'b0;
    send(8'h33, 1'b0, 1'b1, 1);
    drain("drain_post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_checker.md
RX_FRAME_CHECKER -- requirements
Module: rx_frame_checker

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, stop bits checked per frame, legal range 1..2.
REQ-003 Parameter DEPTH, default 4, output FIFO entries, power of two, minimum 2.
REQ-004 Parameter CNT_W, default 8, width of each error counter.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 frame_valid  in  1  one-cycle strobe; frame fields valid this cycle.
REQ-008 frame_data  in  DATA_W  received data bits.
REQ-009 frame_parity  in  1  received parity bit; ignored when par_en=0.
REQ-010 frame_stop  in  STOP_BITS  received stop bits; a 1 in every position is expected.
REQ-011 par_en  in  1  1 = parity checked, 0 = no parity.
REQ-012 p_type  in  1  0 = odd parity, 1 = even parity.
REQ-013 out_valid  out  1  FIFO head holds a checked frame.
REQ-014 out_ready  in  1  consumer accepts the head when out_valid=1.
REQ-015 out_data  out  DATA_W  head data.
REQ-016 out_par_err  out  1  head parity error flag.
REQ-017 out_frm_err  out  1  head framing error flag.
REQ-018 overrun  out  1  one-cycle pulse; a frame was dropped.
REQ-019 clr_cnt  in  1  synchronous clear of all counters.
REQ-020 par_err_cnt, frm_err_cnt, ovr_cnt  out  CNT_W each  saturating error counters.

Function
REQ-021 Stage 1 shall register frame_data, frame_parity, frame_stop, par_en and p_type when frame_valid=1, and shall set s1_valid for exactly one cycle.
REQ-022 Parity error = par_en & (p_type ? ^{data,parity} : ~^{data,parity}); total ones including the parity bit must be odd for p_type=0 and even for p_type=1.
REQ-023 Framing error = any bit of the stored frame_stop equal to 0.
REQ-024 Both errors shall be computed from stage-1 registers, so mid-frame changes to par_en and p_type do not affect a captured frame.
REQ-025 FIFO push shall occur when s1_valid=1 and (count<DEPTH or pop in the same cycle).
REQ-026 Pop shall occur when out_valid & out_ready.
REQ-027 Pop and push when full shall both succeed; count stays DEPTH.
REQ-028 Pop and push when empty: only the push takes effect, with no bypass.
REQ-029 Latency: frame_valid at cycle N, with the FIFO empty, shall give out_valid=1 at cycle N+2.
REQ-030 When s1_valid=1, the FIFO is full and there is no pop, the frame shall be dropped, overrun shall pulse high for one cycle (cycle N+1), and FIFO contents shall be unchanged.
REQ-031 out_data, out_par_err and out_frm_err shall reflect the FIFO head and shall stay stable while out_valid=1 and out_ready=0.
REQ-032 Read and write pointers shall be log2(DEPTH) bits, wrapping modulo DEPTH, with a separate occupancy count of 0..DEPTH.
REQ-033 par_err_cnt and frm_err_cnt shall increment on every s1_valid frame with the corresponding error, including dropped frames.
REQ-034 ovr_cnt shall increment on each overrun.
REQ-035 Counters shall saturate at 2^CNT_W-1.
REQ-036 clr_cnt shall zero all counters on the next edge; clr_cnt has priority over a same-cycle increment.
REQ-037 A new frame_valid on consecutive cycles shall be accepted at one frame per cycle.

Reset
REQ-038 While rst=1, out_valid, overrun, s1_valid, the pointers, the count and all counters shall be 0 at the next edge.
REQ-039 out_data, out_par_err and out_frm_err shall be 0 after reset.
REQ-040 Reset shall take priority over frame_valid, pop and clr_cnt in the same cycle.
REQ-041 A frame held in stage 1 or in the FIFO during reset shall be discarded without counting.

Verification
REQ-042 DATA_W=8, par_en=1, p_type=1, data 0x5A, parity 0, stop 1 -> at N+2 out_valid=1, out_data=0x5A, out_par_err=0, out_frm_err=0.
REQ-043 p_type=0, data 0x5A, parity 0 -> out_par_err=1 and par_err_cnt=1; the same frame with par_en=0 -> out_par_err=0.
REQ-044 stop=0 with data 0x00 -> out_frm_err=1 and frm_err_cnt=1; STOP_BITS=2 with stop=2'b10 -> out_frm_err=1.
REQ-045 DEPTH=4, out_ready=0, five frames 0x01..0x05 -> one overrun pulse, ovr_cnt=1; draining yields 0x01..0x04 in order.
REQ-046 Full FIFO, out_ready=1 and a frame in the same cycle -> no overrun, count stays 4.
REQ-047 Sixth frame while full with out_ready=0 -> dropped, ovr_cnt=2.
REQ-048 CNT_W=2, five parity-error frames -> par_err_cnt=3 (saturated); clr_cnt with a same-cycle error -> 0.
REQ-049 rst asserted with 2 frames queued -> next cycle out_valid=0, all counters 0, and no stale data emerges afterwards.
